// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: memory request/response, redirect input and decode handshake.
interface fetch_unit_if #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // Instruction-memory request channel
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;

  // Instruction-memory response channel (in request order)
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  // Redirect from execute / CSR unit
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Decode handshake
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  // Debug view of in-flight request count
  logic [OUT_W-1:0] outstanding;

  // Fetch unit side
  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, outstanding,
    input  req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  // Memory / decode / redirect source side
  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, outstanding,
    output req_ready, rsp_valid, rsp_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Decoupled RV32 instruction fetch: sequential requests, prefetch FIFO of {inst, pc},
// redirect flush with drop accounting for in-flight responses.
module fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  // Architectural fetch state
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [OUT_W-1:0] outstanding_q;
  logic [OUT_W-1:0] drop_cnt;

  // Prefetch FIFO
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  entry_t           head;

  // Per-cycle events
  logic            credit_ok;
  logic            req_fire;
  logic            drop_rsp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  // Credit: never have more requests in flight than free FIFO slots can absorb
  always_comb begin
    credit_ok = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                ((32'(outstanding_q) + 32'(fifo_count)) < FIFO_DEPTH);
  end

  assign bus.req_valid   = !rst && !bus.redirect_valid && credit_ok;
  assign bus.req_addr    = fetch_pc;
  assign bus.outstanding = outstanding_q;

  // Event decode; a redirect cancels any same-cycle push or pop
  always_comb begin
    req_fire = bus.req_valid && bus.req_ready;
    drop_rsp = bus.rsp_valid && (drop_cnt != '0);
    push     = bus.rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
    pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    target   = {bus.redirect_pc[XLEN-1:2], 2'b00};
  end

  // Head of FIFO straight from storage; zero when empty
  always_comb begin
    head           = fifo_mem[rd_ptr];
    bus.inst_valid = (fifo_count != '0);
    bus.inst       = bus.inst_valid ? head.inst : '0;
    bus.inst_pc    = bus.inst_valid ? head.pc   : '0;
  end

  // FIFO storage write; occupancy tracking makes reset of the array unnecessary
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= '{inst: bus.rsp_data, pc: rsp_pc};
    end
  end

  // PC, credit, drop and FIFO pointer state
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      rsp_pc        <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream
      fetch_pc      <= target;
      rsp_pc        <= target;
      outstanding_q <= outstanding_q - OUT_W'(bus.rsp_valid);
      drop_cnt      <= outstanding_q - OUT_W'(bus.rsp_valid);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      outstanding_q <= outstanding_q + OUT_W'(req_fire) - OUT_W'(bus.rsp_valid);
      if (drop_rsp) begin
        drop_cnt <= drop_cnt - OUT_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Structural invariants of the credit scheme
  a_out_max: assert property (@(posedge clk) disable iff (rst)
    outstanding_q <= OUT_W'(MAX_OUTSTANDING))
    else $error("outstanding above limit");

  a_drop_le_out: assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= outstanding_q)
    else $error("drop_cnt above outstanding");

  a_count_max: assert property (@(posedge clk) disable iff (rst)
    32'(fifo_count) <= FIFO_DEPTH)
    else $error("fifo_count above depth");

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (32'(fifo_count) == FIFO_DEPTH)))
    else $error("push into full fifo");

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(bus.rsp_valid && (outstanding_q == '0)))
    else $error("response with nothing outstanding");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order latency-configurable memory model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32), .MAX_OUTSTANDING(2)) bus();

  fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int max_out = 0;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] issued    [$];
  logic [31:0] dpc       [$];
  logic [31:0] dinst     [$];

  // One clock of memory model, request/delivery logging, then drive next response
  task automatic tick();
    #1;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (bus.rsp_valid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        pend_addr.push_back(bus.req_addr);
        pend_due.push_back(cyc + lat);
        issued.push_back(bus.req_addr);
      end
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        dpc.push_back(bus.inst_pc);
        dinst.push_back(bus.inst);
      end
      if (int'(bus.outstanding) > max_out) max_out = int'(bus.outstanding);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = pend_addr[0] + 32'h100;
    end else begin
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = 32'h0;
    end
  endtask

  task automatic clear_logs();
    issued.delete();
    dpc.delete();
    dinst.delete();
    max_out = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    #1;
    total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", bus.req_valid); end
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b want=0", bus.inst_valid); end
    total++; if (bus.outstanding !== 2'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", bus.inst); end
    total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h want=0", bus.inst_pc); end
    rst = 1'b0;
    #1;
    total++; if (bus.req_valid !== 1'b1) begin bad++; $display("FAIL post_reset_req_valid got=%b want=1", bus.req_valid); end
    total++; if (bus.req_addr !== 32'h0) begin bad++; $display("FAIL post_reset_req_addr got=%h want=0", bus.req_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (12) tick();
    total++; if (issued.size() != 12) begin bad++; $display("FAIL stream_issue_count got=%0d want=12", issued.size()); end
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      a = (i < issued.size()) ? issued[i] : 32'hDEAD_BEEF;
      total++; if (a !== 32'(4 * i)) begin bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, a, 32'(4 * i)); end
    end
    total++; if (dpc.size() != 10) begin bad++; $display("FAIL stream_deliver_count got=%0d want=10", dpc.size()); end
    for (int i = 0; i < 10; i++) begin
      logic [31:0] p, d;
      p = (i < dpc.size()) ? dpc[i] : 32'hDEAD_BEEF;
      d = (i < dinst.size()) ? dinst[i] : 32'hDEAD_BEEF;
      total++; if (p !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, p, 32'(4 * i)); end
      total++; if (d !== 32'(4 * i + 256)) begin bad++; $display("FAIL stream_inst[%0d] got=%h want=%h", i, d, 32'(4 * i + 256)); end
    end
    total++; if (max_out > 2) begin bad++; $display("FAIL stream_max_outstanding got=%0d want<=2", max_out); end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    repeat (20) tick();
    #1;
    total++; if (issued.size() != 4) begin bad++; $display("FAIL stall_issue_count got=%0d want=4", issued.size()); end
    total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%b want=0", bus.req_valid); end
    total++; if (bus.outstanding !== 2'd0) begin bad++; $display("FAIL stall_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL stall_inst_valid got=%b want=1", bus.inst_valid); end
    total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL stall_head_pc got=%h want=0", bus.inst_pc); end
    total++; if (bus.inst !== 32'h100) begin bad++; $display("FAIL stall_head_inst got=%h want=100", bus.inst); end
    bus.inst_ready = 1'b1;
    clear_logs();
    repeat (10) tick();
    total++; if (dpc.size() != 10) begin bad++; $display("FAIL stall_release_count got=%0d want=10", dpc.size()); end
    for (int i = 0; i < 10; i++) begin
      logic [31:0] p;
      p = (i < dpc.size()) ? dpc[i] : 32'hDEAD_BEEF;
      total++; if (p !== 32'(4 * i)) begin bad++; $display("FAIL stall_release_pc[%0d] got=%h want=%h", i, p, 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    bit found;
    int stale;
    logic [31:0] v;
    do_reset();
    lat = 3;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (issued.size() > 0 && issued[issued.size() - 1] == 32'hC) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL redir_reach_pc12 got=timeout want=issued 0xc"); end
    #1;
    total++; if (bus.outstanding !== 2'd2) begin bad++; $display("FAIL redir_inflight got=%0d want=2", bus.outstanding); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h203;
    #1;
    total++; if (bus.req_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle_req_valid got=%b want=0", bus.req_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    clear_logs();
    repeat (15) tick();
    v = (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h200) begin bad++; $display("FAIL redir_first_addr got=%h want=200", v); end
    v = (dpc.size() > 0) ? dpc[0] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h200) begin bad++; $display("FAIL redir_first_pc got=%h want=200", v); end
    v = (dinst.size() > 0) ? dinst[0] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h300) begin bad++; $display("FAIL redir_first_inst got=%h want=300", v); end
    v = (dpc.size() > 1) ? dpc[1] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h204) begin bad++; $display("FAIL redir_second_pc got=%h want=204", v); end
    stale = 0;
    foreach (dpc[i]) if (dpc[i] == 32'h8 || dpc[i] == 32'hC) stale++;
    total++; if (stale != 0) begin bad++; $display("FAIL redir_stale_pcs got=%0d want=0", stale); end
  endtask

  task automatic test_redirect_full();
    int stale;
    do_reset();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    repeat (20) tick();
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    tick();
    #1;
    total++; if (bus.outstanding !== 2'd1) begin bad++; $display("FAIL rfull_pre_outstanding got=%0d want=1", bus.outstanding); end
    total++; if (bus.inst_pc !== 32'h4) begin bad++; $display("FAIL rfull_pre_head_pc got=%h want=4", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h400;
    tick();
    bus.redirect_valid = 1'b0;
    clear_logs();
    #1;
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rfull_flush_inst_valid got=%b want=0", bus.inst_valid); end
    total++; if (bus.outstanding !== 2'd0) begin bad++; $display("FAIL rfull_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.req_valid !== 1'b1) begin bad++; $display("FAIL rfull_req_valid got=%b want=1", bus.req_valid); end
    total++; if (bus.req_addr !== 32'h400) begin bad++; $display("FAIL rfull_req_addr got=%h want=400", bus.req_addr); end
    repeat (8) tick();
    total++; if (dpc.size() == 0) begin bad++; $display("FAIL rfull_deliver_count got=0 want>0"); end
    stale = 0;
    foreach (dpc[i]) if (dpc[i] !== 32'(32'h400 + 4 * i)) stale++;
    total++; if (stale != 0) begin bad++; $display("FAIL rfull_stale_pcs got=%0d want=0", stale); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_reset();
    lat = 1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    clear_logs();
    repeat (6) tick();
    v = (issued.size() > 0) ? issued[0] : 32'hDEAD_BEEF;
    total++; if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h want=fffffffc", v); end
    v = (issued.size() > 1) ? issued[1] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h want=0", v); end
    v = (dpc.size() > 0) ? dpc[0] : 32'hDEAD_BEEF;
    total++; if (v !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc0 got=%h want=fffffffc", v); end
    v = (dinst.size() > 0) ? dinst[0] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h0000_00FC) begin bad++; $display("FAIL wrap_inst0 got=%h want=000000fc", v); end
    v = (dpc.size() > 1) ? dpc[1] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h0) begin bad++; $display("FAIL wrap_pc1 got=%h want=0", v); end
    v = (dinst.size() > 1) ? dinst[1] : 32'hDEAD_BEEF;
    total++; if (v !== 32'h100) begin bad++; $display("FAIL wrap_inst1 got=%h want=100", v); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 2;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b0;
    repeat (6) tick();
    #1;
    total++; if (bus.outstanding !== 2'd1) begin bad++; $display("FAIL rmid_pre_outstanding got=%0d want=1", bus.outstanding); end
    total++; if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_inst_valid got=%b want=1", bus.inst_valid); end
    rst = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = 32'h0;
    tick();
    rst = 1'b0;
    #1;
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rmid_inst_valid got=%b want=0", bus.inst_valid); end
    total++; if (bus.outstanding !== 2'd0) begin bad++; $display("FAIL rmid_outstanding got=%0d want=0", bus.outstanding); end
    total++; if (bus.req_valid !== 1'b1) begin bad++; $display("FAIL rmid_req_valid got=%b want=1", bus.req_valid); end
    total++; if (bus.req_addr !== 32'h0) begin bad++; $display("FAIL rmid_req_addr got=%h want=0", bus.req_addr); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
